// File: rtl/tt_mux_sel_seq.sv
// Mux select sequencer: drives the ctrl_ena / ctrl_sel_inc / ctrl_sel_rst_n pads
// through disable, counter reset, N increment pulses and re-enable.
module tt_mux_sel_seq #(
    parameter int ADDR_W  = 10,
    parameter int RST_CYC = 4,
    parameter int INC_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_ena,
    output logic              ctrl_ena,
    output logic              ctrl_sel_inc,
    output logic              ctrl_sel_rst_n,
    output logic              busy,
    output logic              done,
    output logic              sel_valid,
    output logic [ADDR_W-1:0] cur_addr
);

    // state  | meaning
    // IDLE   | waiting for a request, pads hold last values
    // DIS    | ctrl_ena and ctrl_sel_inc forced low (1 cycle)
    // RST    | ctrl_sel_rst_n low for RST_CYC cycles
    // INC_HI | ctrl_sel_inc high for INC_CYC cycles
    // INC_LO | ctrl_sel_inc low for INC_CYC cycles, one step consumed
    // FIN    | last cycle before ctrl_ena, done and cur_addr update
    typedef enum logic [2:0] {
        S_IDLE,
        S_DIS,
        S_RST,
        S_INC_HI,
        S_INC_LO,
        S_FIN
    } state_t;

    localparam int MAX_CYC = (RST_CYC > INC_CYC) ? RST_CYC : INC_CYC;
    localparam int PH_W    = $clog2(MAX_CYC) + 1;
    localparam logic [PH_W-1:0] RST_LD = PH_W'(RST_CYC - 1);
    localparam logic [PH_W-1:0] INC_LD = PH_W'(INC_CYC - 1);

    state_t              state_q, state_d;
    logic [PH_W-1:0]     phase_q, phase_d;
    logic [ADDR_W-1:0]   step_q, step_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                ena_q, ena_d;
    logic                req_ready_q, req_ready_d;
    logic                ctrl_ena_q, ctrl_ena_d;
    logic                ctrl_sel_inc_q, ctrl_sel_inc_d;
    logic                ctrl_sel_rst_n_q, ctrl_sel_rst_n_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                sel_valid_q, sel_valid_d;
    logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
    logic [ADDR_W-1:0]   step_dec;
    logic [PH_W-1:0]     phase_dec;

    assign step_dec  = step_q - ADDR_W'(1);
    assign phase_dec = phase_q - PH_W'(1);

    always_comb begin
        state_d          = state_q;
        phase_d          = phase_q;
        step_d           = step_q;
        addr_d           = addr_q;
        ena_d            = ena_q;
        req_ready_d      = req_ready_q;
        ctrl_ena_d       = ctrl_ena_q;
        ctrl_sel_inc_d   = ctrl_sel_inc_q;
        ctrl_sel_rst_n_d = ctrl_sel_rst_n_q;
        busy_d           = busy_q;
        done_d           = 1'b0;
        sel_valid_d      = sel_valid_q;
        cur_addr_d       = cur_addr_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    state_d        = S_DIS;
                    addr_d         = req_addr;
                    ena_d          = req_ena;
                    step_d         = req_addr;
                    busy_d         = 1'b1;
                    sel_valid_d    = 1'b0;
                    req_ready_d    = 1'b0;
                    ctrl_ena_d     = 1'b0;
                    ctrl_sel_inc_d = 1'b0;
                end
            end
            S_DIS: begin
                state_d          = S_RST;
                phase_d          = RST_LD;
                ctrl_sel_rst_n_d = 1'b0;
            end
            S_RST: begin
                if (phase_q != '0) begin
                    phase_d = phase_dec;
                end else begin
                    ctrl_sel_rst_n_d = 1'b1;
                    if (step_q == '0) begin
                        state_d = S_FIN;
                    end else begin
                        state_d        = S_INC_HI;
                        phase_d        = INC_LD;
                        ctrl_sel_inc_d = 1'b1;
                    end
                end
            end
            S_INC_HI: begin
                if (phase_q != '0) begin
                    phase_d = phase_dec;
                end else begin
                    state_d        = S_INC_LO;
                    phase_d        = INC_LD;
                    ctrl_sel_inc_d = 1'b0;
                end
            end
            S_INC_LO: begin
                if (phase_q != '0) begin
                    phase_d = phase_dec;
                end else begin
                    step_d = step_dec;
                    if (step_dec != '0) begin
                        state_d        = S_INC_HI;
                        phase_d        = INC_LD;
                        ctrl_sel_inc_d = 1'b1;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_FIN: begin
                // Pads are already settled (rst_n high, inc low) so re-enabling is safe here.
                state_d     = S_IDLE;
                ctrl_ena_d  = ena_q;
                done_d      = 1'b1;
                sel_valid_d = 1'b1;
                cur_addr_d  = addr_q;
                busy_d      = 1'b0;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            phase_q          <= '0;
            step_q           <= '0;
            addr_q           <= '0;
            ena_q            <= 1'b0;
            req_ready_q      <= 1'b1;
            ctrl_ena_q       <= 1'b0;
            ctrl_sel_inc_q   <= 1'b0;
            ctrl_sel_rst_n_q <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            sel_valid_q      <= 1'b0;
            cur_addr_q       <= '0;
        end else begin
            state_q          <= state_d;
            phase_q          <= phase_d;
            step_q           <= step_d;
            addr_q           <= addr_d;
            ena_q            <= ena_d;
            req_ready_q      <= req_ready_d;
            ctrl_ena_q       <= ctrl_ena_d;
            ctrl_sel_inc_q   <= ctrl_sel_inc_d;
            ctrl_sel_rst_n_q <= ctrl_sel_rst_n_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            sel_valid_q      <= sel_valid_d;
            cur_addr_q       <= cur_addr_d;
        end
    end

    assign req_ready      = req_ready_q;
    assign ctrl_ena       = ctrl_ena_q;
    assign ctrl_sel_inc   = ctrl_sel_inc_q;
    assign ctrl_sel_rst_n = ctrl_sel_rst_n_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign sel_valid      = sel_valid_q;
    assign cur_addr       = cur_addr_q;

endmodule

// File: doc/tt_mux_sel_seq.md
Name: tt_mux_sel_seq

Overview:
- Sequencer that drives the three multiplexer control pads: ctrl_ena, ctrl_sel_inc and ctrl_sel_rst_n.
- On a request it selects one user design by address, using the pad protocol: disable, reset the selection counter, pulse increment N times, then re-enable.
- Sits between the on-chip management/config logic and the ctrl[2:0] pad drivers.
- Replaces manual bit-banging of the select protocol.

Parameters:
- ADDR_W, 10, width of design address (number of increment pulses).
- RST_CYC, 4, cycles ctrl_sel_rst_n is held low (≥1).
- INC_CYC, 2, cycles per increment high phase and per low phase (≥1).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  select request valid.
- req_ready  output  1  sequencer can accept a request.
- req_addr  input  ADDR_W  design address to select.
- req_ena  input  1  final ctrl_ena level after selection.
- ctrl_ena  output  1  to pad ctrl[0].
- ctrl_sel_inc  output  1  to pad ctrl[1].
- ctrl_sel_rst_n  output  1  to pad ctrl[2].
- busy  output  1  sequence in progress.
- done  output  1  one-cycle pulse at sequence completion.
- sel_valid  output  1  cur_addr reflects the mux selection.
- cur_addr  output  ADDR_W  last completed selection address.

Behaviour:
- Reset (async, rst_n=0), all outputs registered:
  - ctrl_ena=0, ctrl_sel_inc=0, ctrl_sel_rst_n=0, busy=0, done=0, sel_valid=0, cur_addr=0, req_ready=1.
  - FSM goes to IDLE; all counters cleared.
- Handshake:
  - Accept on the rising edge where req_valid=1 and req_ready=1.
  - req_ready=1 only in IDLE.
  - req_addr and req_ena are latched at acceptance; later changes are ignored.
  - req_valid while busy is held off, not dropped; the requester must keep it asserted.
- FSM states:
  - IDLE: outputs hold their last values. On accept, go to DIS; busy=1, sel_valid=0, req_ready=0.
  - DIS, 1 cycle: ctrl_ena=0, ctrl_sel_inc=0. Go to RST.
  - RST, RST_CYC cycles: ctrl_sel_rst_n=0. Then ctrl_sel_rst_n=1 and go to INC_HI, or to FIN if the latched addr=0.
  - INC_HI, INC_CYC cycles: ctrl_sel_inc=1. Then go to INC_LO.
  - INC_LO, INC_CYC cycles: ctrl_sel_inc=0. Decrement the step counter. If the counter is nonzero, go to INC_HI; otherwise go to FIN.
  - FIN, 1 cycle: ctrl_ena=latched req_ena, done=1, sel_valid=1, cur_addr=latched addr, busy=0. Go to IDLE with req_ready=1 on the next cycle.
- Latency:
  - From the acceptance edge to the edge asserting done: L = 2 + RST_CYC + 2·INC_CYC·addr cycles.
  - addr=0 gives 2+RST_CYC.
  - Back-to-back request: next accept no earlier than 1 cycle after done.
- Pad-level guarantees:
  - ctrl_sel_inc only rises while ctrl_sel_rst_n=1 and ctrl_ena=0.
  - ctrl_ena is never 1 while ctrl_sel_inc=1 or ctrl_sel_rst_n=0.
  - No glitches: all pad outputs come straight from flops.
- Width rules:
  - Step counter is ADDR_W bits.
  - Phase counter is clog2(max(RST_CYC,INC_CYC))+1 bits.
  - Maximum addr 2^ADDR_W−1 produces exactly that many pulses, with no wrap.
- Reset mid-sequence:
  - Immediate return to reset values; pads go to ctrl_sel_rst_n=0, ctrl_ena=0, ctrl_sel_inc=0.
  - The partial selection is discarded; sel_valid=0.
- Simultaneous reset release and req_valid=1: accept no earlier than the first rising edge after rst_n deasserts.

Test Plan:
- Reset with req_valid=0 → ctrl_sel_rst_n=0, ctrl_ena=0, ctrl_sel_inc=0, req_ready=1, sel_valid=0, and these hold for 10 cycles.
- Request addr=3, req_ena=1 (defaults) → the following must all hold:
  - one DIS cycle;
  - 4 cycles with ctrl_sel_rst_n=0;
  - exactly 3 ctrl_sel_inc pulses, each 2 high and 2 low;
  - done at accept+18;
  - ctrl_ena=1, cur_addr=3, sel_valid=1.
- Request addr=0, req_ena=0 → no inc pulses, done at accept+6, ctrl_ena=0, cur_addr=0.
- Second request addr=1 raised while busy → req_ready=0 throughout; accepted 1 cycle after the first done; exactly 1 pulse; cur_addr=1.
- rst_n asserted during the 2nd INC_HI of addr=5 → the following must all hold:
  - all pads go to reset values asynchronously;
  - sel_valid=0, no done pulse;
  - a new addr=2 request after release completes normally.
- addr=1023 with RST_CYC=1, INC_CYC=1 → 1023 pulses counted by the bench, done at accept+2049, cur_addr=1023.
